// File: rtl/id_regfile_sb_if.sv
// Decode-side bus of the register file: read ports, write-back port and load scoreboard.
// The master drives addresses/write-back/load issue; the slave returns data and hazard status.
interface id_regfile_sb_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2
);
    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS-1:0]        rd_use;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_busy;
    logic                       equal;
    logic                       stall;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       sb_set;
    logic [ADDR_W-1:0]          sb_addr;
    logic [ADDR_W:0]            busy_count;

    modport master (
        output rd_addr, rd_use, wr_en, wr_addr, wr_data, sb_set, sb_addr,
        input  rd_data, rd_busy, equal, stall, busy_count
    );

    modport slave (
        input  rd_addr, rd_use, wr_en, wr_addr, wr_data, sb_set, sb_addr,
        output rd_data, rd_busy, equal, stall, busy_count
    );
endinterface

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with write-back bypass, branch-compare flag and a
// per-register load scoreboard that produces the load-use stall.
module id_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    id_regfile_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    logic [DATA_W-1:0]          regs_q [DEPTH];
    logic [DEPTH-1:0]           busy_q, busy_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       wr_act, sb_act;
    logic [RD_PORTS*DATA_W-1:0] rd_data_w;
    logic [RD_PORTS-1:0]        rd_busy_w;

    assign wr_act = bus.wr_en  && (bus.wr_addr != '0);
    assign sb_act = bus.sb_set && (bus.sb_addr != '0);

    // Set is applied after clear so a new load replaces the one completing.
    always_comb begin
        busy_d = busy_q;
        if (wr_act) busy_d[bus.wr_addr] = 1'b0;
        if (sb_act) busy_d[bus.sb_addr] = 1'b1;
        busy_d[0] = 1'b0;
        cnt_d = popcount(busy_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_act) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // A completing write is forwarded, so its register must not report busy.
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        assign addr = bus.rd_addr[p*ADDR_W +: ADDR_W];
        assign hit  = bus.wr_en && (bus.wr_addr == addr);
        assign rd_data_w[p*DATA_W +: DATA_W] = (addr == '0) ? '0 :
                                               hit ? bus.wr_data : regs_q[addr];
        assign rd_busy_w[p] = (addr != '0) && busy_q[addr] && !hit;
    end

    assign bus.rd_data    = rd_data_w;
    assign bus.rd_busy    = rd_busy_w;
    assign bus.equal      = (rd_data_w[DATA_W-1:0] == rd_data_w[2*DATA_W-1:DATA_W]);
    assign bus.stall      = |(bus.rd_use & rd_busy_w);
    assign bus.busy_count = cnt_q;
endmodule

// File: tb/tb_id_regfile_sb.sv
// Bench for id_regfile_sb: two configurations (32/5/2 and 16/3/3) driven from a shared
// stimulus stream and compared every cycle against an array-based register/scoreboard model.
module tb_id_regfile_sb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    id_regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2)) ifa ();
    id_regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .RD_PORTS(3)) ifb ();

    id_regfile_sb #(.DATA_W(32), .ADDR_W(5), .RD_PORTS(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa)
    );
    id_regfile_sb #(.DATA_W(16), .ADDR_W(3), .RD_PORTS(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb)
    );

    // shared stimulus; config B sees the low bits of addresses and data
    logic        wr_en, sb_set;
    logic [4:0]  wr_addr, sb_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra [3];
    logic [2:0]  use_v;

    // reference state
    logic [31:0] mA [32];
    bit          bA [32];
    logic [15:0] mB [8];
    bit          bB [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        ifa.wr_en   = wr_en;
        ifa.wr_addr = wr_addr;
        ifa.wr_data = wr_data;
        ifa.sb_set  = sb_set;
        ifa.sb_addr = sb_addr;
        ifa.rd_addr = {ra[1], ra[0]};
        ifa.rd_use  = use_v[1:0];
        ifb.wr_en   = wr_en;
        ifb.wr_addr = wr_addr[2:0];
        ifb.wr_data = wr_data[15:0];
        ifb.sb_set  = sb_set;
        ifb.sb_addr = sb_addr[2:0];
        ifb.rd_addr = {ra[2][2:0], ra[1][2:0], ra[0][2:0]};
        ifb.rd_use  = use_v;
    endtask

    task automatic idle();
        wr_en = 1'b0; sb_set = 1'b0; wr_addr = '0; sb_addr = '0; wr_data = '0;
        ra[0] = '0; ra[1] = '0; ra[2] = '0; use_v = '0;
    endtask

    function automatic logic [31:0] exp_data_a(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return mA[a];
    endfunction

    function automatic logic exp_busy_a(input logic [4:0] a);
        return (a != 0) && bA[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic [15:0] exp_data_b(input logic [2:0] a);
        if (a == 0) return 16'h0;
        if (wr_en && wr_addr[2:0] == a) return wr_data[15:0];
        return mB[a];
    endfunction

    function automatic logic exp_busy_b(input logic [2:0] a);
        return (a != 0) && bB[a] && !(wr_en && wr_addr[2:0] == a);
    endfunction

    function automatic int count_a();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(bA[i]);
        return n;
    endfunction

    function automatic int count_b();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(bB[i]);
        return n;
    endfunction

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic st;
            st = 1'b0;
            for (int p = 0; p < 2; p++) begin
                chk("a_rd_data", 64'(ifa.rd_data[p*32 +: 32]), 64'(exp_data_a(ra[p])));
                chk("a_rd_busy", 64'(ifa.rd_busy[p]), 64'(exp_busy_a(ra[p])));
                st = st | (use_v[p] & exp_busy_a(ra[p]));
            end
            chk("a_equal", 64'(ifa.equal), 64'(exp_data_a(ra[0]) == exp_data_a(ra[1])));
            chk("a_stall", 64'(ifa.stall), 64'(st));
            chk("a_busy_count", 64'(ifa.busy_count), 64'(count_a()));
            st = 1'b0;
            for (int p = 0; p < 3; p++) begin
                chk("b_rd_data", 64'(ifb.rd_data[p*16 +: 16]), 64'(exp_data_b(ra[p][2:0])));
                chk("b_rd_busy", 64'(ifb.rd_busy[p]), 64'(exp_busy_b(ra[p][2:0])));
                st = st | (use_v[p] & exp_busy_b(ra[p][2:0]));
            end
            chk("b_equal", 64'(ifb.equal), 64'(exp_data_b(ra[0][2:0]) == exp_data_b(ra[1][2:0])));
            chk("b_stall", 64'(ifb.stall), 64'(st));
            chk("b_busy_count", 64'(ifb.busy_count), 64'(count_b()));
        end
    end

    // apply current inputs across one rising edge and advance the model
    task automatic step();
        drive();
        @(negedge clk);
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin mA[i] = '0; bA[i] = 1'b0; end
            for (int i = 0; i < 8; i++)  begin mB[i] = '0; bB[i] = 1'b0; end
        end else begin
            if (wr_en && wr_addr != 0)      begin mA[wr_addr] = wr_data; bA[wr_addr] = 1'b0; end
            if (sb_set && sb_addr != 0)     bA[sb_addr] = 1'b1;
            if (wr_en && wr_addr[2:0] != 0) begin mB[wr_addr[2:0]] = wr_data[15:0]; bB[wr_addr[2:0]] = 1'b0; end
            if (sb_set && sb_addr[2:0] != 0) bB[sb_addr[2:0]] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 6));
    endfunction

    initial begin
        reset_n = 1'b0;
        idle();
        step();
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // reset then read 0, 5, 31
        ra[0] = 5'd0; ra[1] = 5'd5; ra[2] = 5'd31; drive(); #1;
        chk("rst_rd0", 64'(ifa.rd_data[31:0]), 64'h0);
        chk("rst_rd1", 64'(ifa.rd_data[63:32]), 64'h0);
        chk("rst_equal", 64'(ifa.equal), 64'h1);
        chk("rst_count", 64'(ifa.busy_count), 64'h0);
        ra[0] = 5'd31; drive(); #1;
        chk("rst_rd31", 64'(ifa.rd_data[31:0]), 64'h0);
        chk("rst_b_rd2", 64'(ifb.rd_data[47:32]), 64'h0);
        step();

        // write with same-cycle bypass, then from the array
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; ra[0] = 5'd7; ra[2] = 5'd7;
        drive(); #1;
        chk("bypass_a", 64'(ifa.rd_data[31:0]), 64'hDEADBEEF);
        chk("bypass_b_p2", 64'(ifb.rd_data[47:32]), 64'hBEEF);
        step();
        wr_en = 1'b0; drive(); #1;
        chk("stored_a", 64'(ifa.rd_data[31:0]), 64'hDEADBEEF);
        chk("stored_b_p2", 64'(ifb.rd_data[47:32]), 64'hBEEF);
        step();

        // register 0 ignores writes and loads
        idle(); wr_en = 1'b1; wr_data = 32'h1234; sb_set = 1'b1; use_v = 3'b111;
        drive(); #1;
        chk("zero_rd", 64'(ifa.rd_data[31:0]), 64'h0);
        chk("zero_stall", 64'(ifa.stall), 64'h0);
        step();
        idle(); use_v = 3'b111; drive(); #1;
        chk("zero_count", 64'(ifa.busy_count), 64'h0);
        chk("zero_stall2", 64'(ifa.stall), 64'h0);

        // load-use stall on register 9 (register 1 in config B)
        idle(); sb_set = 1'b1; sb_addr = 5'd9; step();
        idle(); ra[1] = 5'd9; ra[2] = 5'd9; use_v = 3'b110; drive(); #1;
        chk("lu_stall_a", 64'(ifa.stall), 64'h1);
        chk("lu_count_a", 64'(ifa.busy_count), 64'h1);
        chk("lu_busy_b_p2", 64'(ifb.rd_busy[2]), 64'h1);
        chk("lu_stall_b", 64'(ifb.stall), 64'h1);
        use_v = 3'b000; drive(); #1;
        chk("lu_nouse_a", 64'(ifa.stall), 64'h0);
        chk("lu_nouse_b", 64'(ifb.stall), 64'h0);
        step();
        use_v = 3'b110; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; drive(); #1;
        chk("lu_clear_stall_a", 64'(ifa.stall), 64'h0);
        chk("lu_clear_data_a", 64'(ifa.rd_data[63:32]), 64'h55);
        chk("lu_clear_stall_b", 64'(ifb.stall), 64'h0);
        chk("lu_clear_data_b_p2", 64'(ifb.rd_data[47:32]), 64'h55);
        step();
        wr_en = 1'b0; drive(); #1;
        chk("lu_count_after", 64'(ifa.busy_count), 64'h0);
        chk("lu_count_after_b", 64'(ifb.busy_count), 64'h0);

        // simultaneous set and clear on register 3
        idle(); sb_set = 1'b1; sb_addr = 5'd3; step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77; step();
        idle(); ra[0] = 5'd3; ra[2] = 5'd3; drive(); #1;
        chk("setclr_busy", 64'(ifa.rd_busy[0]), 64'h1);
        chk("setclr_count", 64'(ifa.busy_count), 64'h1);
        chk("setclr_busy_b_p2", 64'(ifb.rd_busy[2]), 64'h1);

        // mid-operation reset with a write in the same cycle
        idle(); sb_set = 1'b1;
        sb_addr = 5'd1; step();
        sb_addr = 5'd2; step();
        idle(); drive(); #1;
        chk("mid_count3", 64'(ifa.busy_count), 64'h3);
        reset_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hFFFF; step();
        reset_n = 1'b1; idle(); ra[0] = 5'd7; ra[1] = 5'd3; ra[2] = 5'd7; use_v = 3'b111;
        drive(); #1;
        chk("mid_count0", 64'(ifa.busy_count), 64'h0);
        chk("mid_stall", 64'(ifa.stall), 64'h0);
        chk("mid_rd7", 64'(ifa.rd_data[31:0]), 64'h0);
        chk("mid_b_rd2", 64'(ifb.rd_data[47:32]), 64'h0);
        chk("mid_b_stall", 64'(ifb.stall), 64'h0);
        step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 149) != 0);
            wr_en   = ($urandom_range(0, 9) < 4);
            wr_addr = rand_addr();
            wr_data = $urandom;
            sb_set  = ($urandom_range(0, 1) == 1);
            sb_addr = rand_addr();
            ra[0]   = rand_addr();
            ra[1]   = ($urandom_range(0, 3) == 0) ? ra[0] : rand_addr();
            ra[2]   = rand_addr();
            use_v   = 3'($urandom_range(0, 7));
            step();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_regfile_sb.md
# id_regfile_sb

Parametrised register file for the decode stage with a built-in load scoreboard. It offers RD_PORTS asynchronous read ports and one write port driven by write-back, with write-to-read bypass in the same cycle and a branch-compare flag on read ports 0/1. A per-register pending bit is set when a load issues and cleared when write-back lands. From these bits the block raises a decode stall, so the separate load-use comparator is no longer needed.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W, register 0 hardwired to zero
- RD_PORTS, 2, number of read ports (>= 2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- rd_addr  in  RD_PORTS*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_use  in  RD_PORTS  port p address is a true source operand of the decoding instruction
- rd_data  out  RD_PORTS*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  RD_PORTS  port p reads a register whose load result is still outstanding
- equal  out  1  rd_data port 0 == rd_data port 1 (after bypass)
- stall  out  1  OR over p of (rd_use[p] & rd_busy[p])
- wr_en  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back address
- wr_data  in  DATA_W  write-back data
- sb_set  in  1  a load is issuing from decode this cycle (already qualified by the stall)
- sb_addr  in  ADDR_W  destination of the issuing load
- busy_count  out  ADDR_W+1  number of registers currently marked pending

## Operation
- Storage: 2**ADDR_W x DATA_W array. Register 0 always reads 0. Writes and sb_set to address 0 are ignored.
- Write: on rising edge, if reset_n=1, wr_en=1 and wr_addr!=0, then regs[wr_addr] <= wr_data.
- Read (combinational), per port:
  - If rd_addr==0, rd_data = 0.
  - Else if wr_en && wr_addr==rd_addr, rd_data = wr_data (bypass).
  - Else rd_data = regs[rd_addr].
- equal compares the post-bypass port 0 and port 1 values.
- Scoreboard: busy vector of width 2**ADDR_W, bit 0 always 0. The next-state rules at the rising edge, for address a != 0, are:
  - If sb_set and sb_addr==a, busy[a] <= 1. Set wins over a same-cycle clear, because a new load replaces the one completing.
  - Else if wr_en and wr_addr==a, busy[a] <= 0.
  - Else busy[a] holds.
- rd_busy[p] = busy[rd_addr_p] & ~(wr_en && wr_addr==rd_addr_p). The completing write is bypassed, so it must not stall.
- rd_busy[p] is 0 for address 0.
- sb_set to an address that is already busy leaves it busy (no count change). wr_en to a non-busy register is an ordinary write.
- busy_count is registered. It equals the popcount of the next-state busy vector, updated on the same edge as busy. The maximum is 2**ADDR_W - 1.
- Reset (reset_n=0 at an edge) clears all registers, all busy bits and busy_count. Reset dominates wr_en and sb_set in the same cycle. Reset can occur mid-operation; all pending loads are then forgotten.

## Timing
- Read path, rd_busy, equal and stall are purely combinational from the inputs and current state, with zero-cycle latency.
- Write data is visible through bypass in the write cycle and from the array from the next cycle on.
- A busy bit set at edge N affects rd_busy/stall from cycle N+1 onward.
- A clearing write at edge M removes rd_busy already in cycle M, via the bypass term.
- After the first reset edge: every rd_data=0, rd_busy=0, equal=1, stall=0, busy_count=0.
- Before the first reset edge, outputs are undefined.

## Test plan
- Reset then read: hold reset_n=0 for 1 edge, release, read addresses 0, 5 and 31 -> all rd_data=0, equal=1, busy_count=0.
- Write and bypass: wr_en=1, wr_addr=7, wr_data=0xDEADBEEF, rd_addr port0=7 in the same cycle -> rd_data0=0xDEADBEEF combinationally. Next cycle with wr_en=0 -> still 0xDEADBEEF.
- Zero register: write 0x1234 to address 0 and sb_set to address 0 -> read of address 0 returns 0, busy_count stays 0, stall=0.
- Load-use stall:
  - sb_set, sb_addr=9 at edge N -> cycle N+1 with rd_addr port1=9, rd_use=2'b10: stall=1, busy_count=1.
  - Same state with rd_use=2'b00 -> stall=0.
  - wr_en to 9 with data 0x55 -> same cycle stall=0 and rd_data1=0x55; next edge busy_count=0.
- Simultaneous set/clear: reg 3 busy; in one cycle wr_en to 3 and sb_set to 3 -> after the edge, busy[3] stays 1 (rd_busy=1 on a read of 3) and busy_count is unchanged.
- Mid-operation reset and parameters:
  - Mark registers 1, 2, 3 busy (count 3), then reset_n=0 with wr_en=1 -> after the edge, count=0, stall=0, the written register reads 0.
  - Repeat with DATA_W=16, ADDR_W=3, RD_PORTS=3 -> port 2 bypass and stall behave identically.
